// File: rtl/dac_spi_pkg.sv
// Shared types and sizing helpers for the serial DAC writer.
package dac_spi_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_SETUP,
        S_SHIFT,
        S_HOLD,
        S_GAP
    } state_t;

    // Half-periods in one frame including the trailing gap.
    function automatic int unsigned frame_hp(input int unsigned bits, input int unsigned gap);
        return 2 * bits + 2 + gap;
    endfunction

    function automatic int unsigned cnt_w(input int unsigned n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/dac_spi_writer_hb_tick_gen.sv
// Half-period rate divider: tick pulses once every HBDIV clk while en is high.
module hb_tick_gen
    import dac_spi_pkg::*;
#(
    parameter int unsigned HBDIV = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic en,
    output logic tick
);

    localparam int unsigned CW = cnt_w(HBDIV);
    localparam logic [CW-1:0] TC = CW'(HBDIV - 1);

    logic [CW-1:0] cnt;

    always_ff @(posedge clk) begin
        if (rst || !en) begin
            cnt <= '0;
        end else if (cnt == TC) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + CW'(1);
        end
    end

    assign tick = en && (cnt == TC);

endmodule

// File: rtl/dac_spi_writer.sv
// Serial DAC driver: valid/ready sample input, MSB-first frames on sck/sync_n/sdo.
// Define DAC_LDAC_EN to add ldac_n, pulsed low for the first gap half-period after each frame.
module dac_spi_writer
    import dac_spi_pkg::*;
#(
    parameter int unsigned HBDIV = 4,
    parameter int unsigned BITS  = 24,
    parameter int unsigned GAP   = 2
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [BITS-1:0] din,
    input  logic            din_valid,
    output logic            din_ready,
    output logic            busy,
    output logic            sck,
    output logic            sync_n,
    output logic            sdo
`ifdef DAC_LDAC_EN
    ,
    output logic            ldac_n
`endif
);

    localparam int unsigned FHP = frame_hp(BITS, GAP);
    localparam int unsigned HW  = cnt_w(FHP);
    localparam logic [HW-1:0] HP_SHIFT_END = HW'(2 * BITS);
    localparam logic [HW-1:0] HP_GAP_FIRST = HW'(2 * BITS + 2);
    localparam logic [HW-1:0] HP_LAST      = HW'(FHP - 1);

    state_t          state, state_nx;
    logic [HW-1:0]   hp, hp_nx;
    logic [BITS-1:0] pend, shifter;
    logic            pend_full, pend_full_nx;
    logic            hb_tick;
    logic            accept, consume, shift_en;
    logic            sync_nx, sck_nx, sdo_nx;
`ifdef DAC_LDAC_EN
    logic            ldac_nx;
`endif

    hb_tick_gen #(.HBDIV(HBDIV)) u_tick (
        .clk  (clk),
        .rst  (rst),
        .en   (state != S_IDLE),
        .tick (hb_tick)
    );

    // hp indexes the half-period within the frame: 0 setup, 1..2*BITS shift
    // (odd = sck high), 2*BITS+1 hold, the remainder is the gap.
    always_comb begin
        state_nx = state;
        hp_nx    = hp;
        if (state == S_IDLE) begin
            hp_nx = '0;
            if (pend_full) state_nx = S_SETUP;
        end else if (hb_tick) begin
            hp_nx = hp + HW'(1);
            case (state)
                S_SETUP: state_nx = S_SHIFT;
                S_SHIFT: if (hp == HP_SHIFT_END) state_nx = S_HOLD;
                S_HOLD:  state_nx = S_GAP;
                S_GAP: begin
                    if (hp == HP_LAST) begin
                        hp_nx    = '0;
                        state_nx = pend_full ? S_SETUP : S_IDLE;
                    end
                end
                default: state_nx = S_IDLE;
            endcase
        end
    end

    // Pin values are computed from the current state and registered, so the
    // bus trails the state register by one clk.
    always_comb begin
        accept       = din_valid && !pend_full;
        consume      = (state_nx == S_SETUP) && (state != S_SETUP);
        pend_full_nx = pend_full;
        if (consume) pend_full_nx = 1'b0;
        if (accept)  pend_full_nx = 1'b1;
        shift_en = (state == S_SHIFT) && hb_tick && !hp[0] && (hp != HP_SHIFT_END);

        sync_nx = 1'b1;
        sck_nx  = 1'b0;
        sdo_nx  = 1'b0;
`ifdef DAC_LDAC_EN
        ldac_nx = 1'b1;
`endif
        case (state)
            S_SETUP: begin
                sync_nx = 1'b0;
                sdo_nx  = shifter[BITS-1];
            end
            S_SHIFT: begin
                sync_nx = 1'b0;
                sck_nx  = hp[0];
                sdo_nx  = shifter[BITS-1];
            end
            S_HOLD: begin
                sync_nx = 1'b0;
                sdo_nx  = sdo;
            end
`ifdef DAC_LDAC_EN
            S_GAP:   ldac_nx = (hp != HP_GAP_FIRST);
`endif
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= S_IDLE;
            hp        <= '0;
            pend      <= '0;
            pend_full <= 1'b0;
            shifter   <= '0;
            din_ready <= 1'b1;
            busy      <= 1'b0;
            sck       <= 1'b0;
            sync_n    <= 1'b1;
            sdo       <= 1'b0;
`ifdef DAC_LDAC_EN
            ldac_n    <= 1'b1;
`endif
        end else begin
            state     <= state_nx;
            hp        <= hp_nx;
            pend_full <= pend_full_nx;
            if (accept) pend <= din;
            if (consume) begin
                shifter <= pend;
            end else if (shift_en) begin
                shifter <= shifter << 1;
            end
            din_ready <= !pend_full_nx;
            busy      <= (state_nx != S_IDLE) || pend_full_nx;
            sck       <= sck_nx;
            sync_n    <= sync_nx;
            sdo       <= sdo_nx;
`ifdef DAC_LDAC_EN
            ldac_n    <= ldac_nx;
`endif
        end
    end

endmodule

// File: tb/tb_dac_spi_writer.sv
// Bench for dac_spi_writer: frame-level timing model, bus capture on sck falling edges, directed tests.
// Build with DAC_LDAC_EN defined to also cover ldac_n.
`timescale 1ns/1ps
module tb_dac_spi_writer;

    localparam int HB = 2;
    localparam int NB = 24;
    localparam int GP = 2;
    localparam int P  = HB * (2 * NB + 2 + GP);

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [NB-1:0] din = '0;
    logic          din_valid = 1'b0;
    logic          din_ready, busy, sck, sync_n, sdo;
    logic [0:0]    c_din = 1'b0;
    logic          c_valid = 1'b0;
    logic          c_ready, c_busy, c_sck, c_sync_n, c_sdo;
`ifdef DAC_LDAC_EN
    logic          ldac_n, c_ldac_n;
`endif

    always #5 clk = ~clk;

    dac_spi_writer #(.HBDIV(HB), .BITS(NB), .GAP(GP)) dut (
        .clk(clk), .rst(rst), .din(din), .din_valid(din_valid), .din_ready(din_ready),
        .busy(busy), .sck(sck), .sync_n(sync_n), .sdo(sdo)
`ifdef DAC_LDAC_EN
        , .ldac_n(ldac_n)
`endif
    );

    dac_spi_writer #(.HBDIV(1), .BITS(1), .GAP(1)) dut_c (
        .clk(clk), .rst(rst), .din(c_din), .din_valid(c_valid), .din_ready(c_ready),
        .busy(c_busy), .sck(c_sck), .sync_n(c_sync_n), .sdo(c_sdo)
`ifdef DAC_LDAC_EN
        , .ldac_n(c_ldac_n)
`endif
    );

    int errors = 0;
    int checks = 0;
    int cyc = 0;
    bit chk_en = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Model: one pending word plus the frame currently on the bus, each frame
    // described only by its sync_n-fall cycle and its data word.
    bit            pend_m = 1'b0;
    logic [NB-1:0] pend_w;
    int            pend_s;
    bit            cur_act = 1'b0;
    logic [NB-1:0] cur_w;
    int            cur_s;
    logic [NB-1:0] expq[$];
    int            t, hpi;
    logic          e_sync, e_sck, e_sdo, e_ldac, e_busy, e_rdy;

    // Bus capture.
    logic          prev_sck = 1'b0, prev_sync = 1'b1, prev_ldac = 1'b1;
    int            falls = 0, low_len = 0, high_len = 0;
    int            last_low = 0, last_falls = 0, last_gap = -1;
    int            words = 0, aborts = 0;
    logic [NB-1:0] cap = '0, last_word = '0;
    int            ldac_len = 0, last_ldac_len = 0, ldac_pulses = 0;
    logic          ldac_at_rise = 1'b1;

    always @(negedge clk) begin
        if (chk_en) begin
            t = cyc;
            if (pend_m && t == pend_s - 1) begin
                cur_act = 1'b1;
                cur_w   = pend_w;
                cur_s   = pend_s;
                pend_m  = 1'b0;
            end
            e_sync = 1'b1; e_sck = 1'b0; e_sdo = 1'b0; e_ldac = 1'b1;
            if (cur_act && t >= cur_s && t < cur_s + P) begin
                hpi = (t - cur_s) / HB;
                if (hpi < 2 * NB + 2) begin
                    e_sync = 1'b0;
                    if (hpi == 0) begin
                        e_sdo = cur_w[NB-1];
                    end else if (hpi <= 2 * NB) begin
                        e_sck = (hpi % 2 == 1);
                        e_sdo = cur_w[NB - 1 - (hpi - 1) / 2];
                    end else begin
                        e_sdo = cur_w[0];
                    end
                end else if (hpi == 2 * NB + 2) begin
                    e_ldac = 1'b0;
                end
            end
            e_busy = pend_m || (cur_act && t >= cur_s - 1 && t <= cur_s + P - 2);
            e_rdy  = !pend_m;
`ifdef DAC_LDAC_EN
            check("pins(rdy,busy,sck,sync_n,sdo,ldac_n)",
                  {din_ready, busy, sck, sync_n, sdo, ldac_n},
                  {e_rdy, e_busy, e_sck, e_sync, e_sdo, e_ldac});
            if (ldac_n === 1'b0) ldac_len++;
            else if (prev_ldac === 1'b0) begin
                last_ldac_len = ldac_len;
                ldac_len = 0;
                ldac_pulses++;
            end
            prev_ldac = ldac_n;
`else
            check("pins(rdy,busy,sck,sync_n,sdo)",
                  {din_ready, busy, sck, sync_n, sdo},
                  {e_rdy, e_busy, e_sck, e_sync, e_sdo});
`endif

            if (prev_sync == 1'b0 && sync_n == 1'b1) begin
`ifdef DAC_LDAC_EN
                ldac_at_rise = ldac_n;
`endif
                last_low   = low_len;
                last_falls = falls;
                if (falls == NB) begin
                    words++;
                    last_word = cap;
                    if (expq.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL captured_word: got %0h expected none", cap);
                    end else begin
                        check("captured_word", cap, expq.pop_front());
                    end
                end else begin
                    aborts++;
                end
            end
            if (prev_sync == 1'b1 && sync_n == 1'b0) begin
                last_gap = high_len;
                falls    = 0;
                low_len  = 0;
            end
            if (sync_n == 1'b0) begin
                low_len++;
                high_len = 0;
                if (prev_sck && !sck) begin
                    cap = {cap[NB-2:0], sdo};
                    falls++;
                end
            end else begin
                high_len++;
            end

            if (rst) begin
                pend_m  = 1'b0;
                cur_act = 1'b0;
                expq.delete();
            end else if (din_valid && !pend_m) begin
                pend_m = 1'b1;
                pend_w = din;
                pend_s = t + 3;
                if (cur_act && cur_s + P > pend_s) pend_s = cur_s + P;
                expq.push_back(din);
            end
            prev_sck  = sck;
            prev_sync = sync_n;
        end
    end

    // Corner instance monitor.
    int   c_low = 0, c_high = 0, c_falls = 0;
    logic c_bit = 1'b0, c_prev_sck = 1'b0;

    always @(negedge clk) begin
        if (chk_en) begin
            if (c_sync_n == 1'b0) begin
                c_low++;
                if (c_sck) c_high++;
                if (c_prev_sck && !c_sck) begin
                    c_bit = c_sdo;
                    c_falls++;
                end
            end
            c_prev_sck = c_sck;
        end
    end

    task automatic send(input logic [NB-1:0] w, output int stalls);
        int  n;
        bit  acc;
        din       = w;
        din_valid = 1'b1;
        n         = 0;
        stalls    = 0;
        do begin
            @(negedge clk);
            acc = din_ready;
            @(posedge clk);
            #1;
            if (!acc) stalls++;
            n++;
        end while (!acc && n < 2000);
        if (!acc) begin
            checks++;
            errors++;
            $display("FAIL send_timeout: word %0h not accepted in %0d cycles", w, n);
        end
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while (busy !== 1'b0 && n < 2000) begin
            @(posedge clk);
            #1;
            n++;
        end
        if (n >= 2000) begin
            checks++;
            errors++;
            $display("FAIL idle_timeout: busy still %b after %0d cycles", busy, n);
        end
        repeat (4) @(posedge clk);
        #1;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int st, st3, w0, p0, n;

        repeat (3) @(posedge clk);
        #1;
        rst    = 1'b0;
        chk_en = 1'b1;
        check("reset_state(rdy,busy,sck,sync_n,sdo)", {din_ready, busy, sck, sync_n, sdo}, 5'b10010);
`ifdef DAC_LDAC_EN
        check("reset_ldac_n", ldac_n, 1'b1);
`endif
        repeat (2) @(posedge clk);
        #1;

        // Single word.
        send(24'hA55AC3, st);
        din_valid = 1'b0;
        wait_idle();
        check("single_low_len", last_low, 100);
        check("single_falls", last_falls, 24);
        check("single_word", last_word, 24'hA55AC3);
        check("single_idle(busy,sync_n,sck)", {busy, sync_n, sck}, 3'b010);
`ifdef DAC_LDAC_EN
        check("ldac_low_len", last_ldac_len, 2);
        check("ldac_at_sync_rise", ldac_at_rise, 1'b0);
`endif

        // Back-to-back with valid held.
        w0 = words;
        send(24'h000001, st);
        send(24'hFFFFFE, st);
        din_valid = 1'b0;
        check("b2b_accept_in_frame_sync_n", sync_n, 1'b0);
        wait_idle();
        check("b2b_gap_len", last_gap, 4);
        check("b2b_words", words - w0, 2);
        check("b2b_last_word", last_word, 24'hFFFFFE);

        // Backpressure with three words.
        w0 = words;
        send(24'h111111, st);
        send(24'h222222, st);
        check("bp_ready_low_when_full", din_ready, 1'b0);
        send(24'h333333, st3);
        din_valid = 1'b0;
        check("bp_third_stalled", (st3 > 90), 1'b1);
        wait_idle();
        check("bp_words", words - w0, 3);
        check("bp_last_word", last_word, 24'h333333);

        // Reset after the 10th sck falling edge.
        send(24'h5A5A5A, st);
        din_valid = 1'b0;
        n = 0;
        do begin
            @(negedge clk);
            #1;
            n++;
        end while (!(sync_n == 1'b0 && falls == 10) && n < 2000);
        check("rst_wait_10_falls", falls, 10);
        @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        check("rst_mid(sync_n,sck,sdo,rdy,busy)", {sync_n, sck, sdo, din_ready, busy}, 5'b10010);
        p0 = ldac_pulses;
        repeat (12) @(posedge clk);
        #1;
        check("rst_no_ldac_pulse", ldac_pulses, p0);
        check("rst_aborts", aborts, 1);
        send(24'h123456, st);
        din_valid = 1'b0;
        wait_idle();
        check("rst_next_word", last_word, 24'h123456);
        check("rst_next_falls", last_falls, 24);
        check("all_words_delivered", expq.size(), 0);
        check("total_words", words, 7);

        // Corner instance: HBDIV=1, BITS=1, GAP=1.
        c_din   = 1'b1;
        c_valid = 1'b1;
        @(posedge clk);
        #1;
        c_valid = 1'b0;
        repeat (12) @(posedge clk);
        #1;
        check("corner_sck_high", c_high, 1);
        check("corner_sync_low", c_low, 4);
        check("corner_falls", c_falls, 1);
        check("corner_bit", c_bit, 1'b1);
        check("corner_idle(busy,sync_n,rdy)", {c_busy, c_sync_n, c_ready}, 3'b011);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
